// File: rtl/i2c_scl_gen.sv
// I2C SCL generator: programmable half-period, clock stretching with timeout,
// multi-master synchronisation, graceful stop and phase strobes for SDA timing.
module i2c_scl_gen #(
   parameter int SIZE_REG   = 16,
   parameter int STRETCH_TO = 1024
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_SCL_en,
   input  logic                i_SCL_start,
   input  logic                i_SCL_stop,
   input  logic [SIZE_REG-1:0] i_TWIBR,
   input  logic [1:0]          i_TWPS,
   input  logic                i_SCL_in,
   output logic                o_scl_oe,
   output logic                o_SCL,
   output logic                o_busy,
   output logic                o_scl_rise,
   output logic                o_scl_fall,
   output logic                o_mid_high,
   output logic                o_mid_low,
   output logic                o_done,
   output logic                o_stretch_to
);

   // state | meaning
   // IDLE  | SCL released, waiting for start
   // LOW   | driving SCL low for h_q cycles
   // HWAIT | released, waiting for the bus to read high (stretching)
   // HIGH  | released and high for h_q cycles, watching for other masters
   localparam int HW = SIZE_REG + 7;
   localparam int SW = $clog2(STRETCH_TO + 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOW   = 2'd1,
      HWAIT = 2'd2,
      HIGH  = 2'd3
   } state_t;

   state_t        r_state, w_state_n;
   logic [HW-1:0] r_cnt, w_cnt_n;
   logic [HW-1:0] r_h, w_h_n;
   logic [HW-1:0] w_h, w_h_half;
   logic [SW-1:0] r_st, w_st_n;
   logic          r_stop, w_stop_n;
   logic          r_sync_meta, r_scl_s;
   logic          r_rise, r_fall, r_done, r_sto;
   logic          w_rise_n, w_fall_n, w_done_n, w_sto_n;
   logic          w_last;

   assign w_h      = (HW'(i_TWIBR) + HW'(1)) << {i_TWPS, 1'b0};
   assign w_h_half = r_h >> 1;
   assign w_last   = (r_cnt == r_h - HW'(1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync_meta <= 1'b1;
         r_scl_s     <= 1'b1;
      end else begin
         r_sync_meta <= i_SCL_in;
         r_scl_s     <= r_sync_meta;
      end
   end

   // Decisions use the value scl_s is about to take, so the state change lands
   // on the same edge as the synchroniser output and HWAIT lasts two cycles.
   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt + HW'(1);
      w_h_n     = r_h;
      w_st_n    = r_st;
      w_stop_n  = r_stop | (i_SCL_stop & (r_state != IDLE));
      w_rise_n  = 1'b0;
      w_fall_n  = 1'b0;
      w_done_n  = 1'b0;
      w_sto_n   = 1'b0;
      case (r_state)
         IDLE: begin
            w_cnt_n = '0;
            w_st_n  = '0;
            if (i_SCL_start) begin
               w_state_n = LOW;
               w_h_n     = w_h;
               w_fall_n  = 1'b1;
            end
         end
         LOW: begin
            if (w_last) begin
               w_cnt_n = '0;
               w_st_n  = '0;
               if (w_stop_n) begin
                  w_state_n = IDLE;
                  w_done_n  = 1'b1;
                  w_stop_n  = 1'b0;
               end else begin
                  w_state_n = HWAIT;
               end
            end
         end
         HWAIT: begin
            w_cnt_n = '0;
            w_st_n  = r_st + SW'(1);
            if (r_sync_meta) begin
               w_state_n = HIGH;
               w_rise_n  = 1'b1;
            end else if ((STRETCH_TO != 0) && (w_st_n == SW'(STRETCH_TO)) && !r_scl_s) begin
               w_state_n = IDLE;
               w_sto_n   = 1'b1;
               w_stop_n  = 1'b0;
            end
         end
         HIGH: begin
            if (!r_sync_meta || w_last) begin
               w_state_n = LOW;
               w_cnt_n   = '0;
               w_h_n     = w_h;
               w_fall_n  = 1'b1;
            end
         end
         default: w_state_n = IDLE;
      endcase
      if (!i_SCL_en) begin
         w_state_n = IDLE;
         w_cnt_n   = '0;
         w_st_n    = '0;
         w_stop_n  = 1'b0;
         w_rise_n  = 1'b0;
         w_fall_n  = 1'b0;
         w_done_n  = 1'b0;
         w_sto_n   = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_h     <= HW'(1);
         r_st    <= '0;
         r_stop  <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_done  <= 1'b0;
         r_sto   <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_h     <= w_h_n;
         r_st    <= w_st_n;
         r_stop  <= w_stop_n;
         r_rise  <= w_rise_n;
         r_fall  <= w_fall_n;
         r_done  <= w_done_n;
         r_sto   <= w_sto_n;
      end
   end

   assign o_scl_oe     = (r_state == LOW);
   assign o_SCL        = ~o_scl_oe;
   assign o_busy       = (r_state != IDLE);
   assign o_scl_rise   = r_rise;
   assign o_scl_fall   = r_fall;
   assign o_done       = r_done;
   assign o_stretch_to = r_sto;
   assign o_mid_low    = (r_state == LOW) && (r_cnt == w_h_half);
   // Suppressed when another master is already pulling SCL low this cycle.
   assign o_mid_high   = (r_state == HIGH) && (r_cnt == w_h_half) && r_sync_meta;

endmodule

// File: doc/i2c_scl_gen.md
# i2c_scl_gen

Parametrised I2C serial-clock generator, successor to `gen_scl`, for the I2C IP master datapath. Generates SCL from a programmable baud register and a 2-bit prescaler, as an open-drain enable. Supports slave clock stretching with timeout, multi-master clock synchronisation and a graceful stop that parks SCL high. Provides phase strobes so the byte/bit controller can shift SDA without its own timing counters.

## Interface
- `SIZE_REG`, 16: width of `i_TWIBR`.
- `STRETCH_TO`, 1024: maximum cycles SCL may be held low by another device while released; 0 disables the timeout.
- `i_clk` in 1: system clock, all logic on rising edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_SCL_en` in 1: block enable; low forces IDLE immediately.
- `i_SCL_start` in 1: single-cycle pulse, start clocking from IDLE.
- `i_SCL_stop` in 1: single-cycle pulse, request graceful stop; held pending until honoured.
- `i_TWIBR` in SIZE_REG: baud divider.
- `i_TWPS` in 2: prescaler exponent.
- `i_SCL_in` in 1: sensed SCL bus level, asynchronous.
- `o_scl_oe` out 1: 1 = drive SCL low, 0 = release.
- `o_SCL` out 1: equals `~o_scl_oe`, intended line level.
- `o_busy` out 1: high in any state except IDLE.
- `o_scl_rise`, `o_scl_fall`, `o_mid_high`, `o_mid_low`, `o_done`, `o_stretch_to` out 1 each: single-cycle strobes.

## Operation
- Half-period H = (i_TWIBR + 1) << (2*i_TWPS). H is computed in SIZE_REG+7 bits, so it never overflows. H is latched into `h_q` on start and on every entry to LOW. Divider changes therefore take effect only at the next falling edge.
- `i_SCL_in` passes through a 2-flop synchroniser giving `scl_s`. `scl_s` resets to 1.
- FSM states are IDLE, LOW, HWAIT and HIGH. The phase counter `cnt` counts 0..H-1 in LOW and HIGH and is cleared on every state entry.
- IDLE: `o_scl_oe`=0. On `i_SCL_start` with `i_SCL_en` high, go to LOW and pulse `o_scl_fall`.
- LOW: `o_scl_oe`=1. `o_mid_low` pulses at cnt = H>>1. At cnt = H-1:
  - if a stop is pending, go to IDLE, pulse `o_done` and clear the pending stop;
  - otherwise go to HWAIT.
- HWAIT: `o_scl_oe`=0, and the stretch counter increments each cycle.
  - When `scl_s`=1, go to HIGH and pulse `o_scl_rise`.
  - If STRETCH_TO≠0 and the stretch counter reaches STRETCH_TO, go to IDLE, pulse `o_stretch_to` and clear any pending stop.
- HIGH: `o_scl_oe`=0. `o_mid_high` pulses at cnt = H>>1; this is the SDA sample point.
  - If `scl_s`=0 at any cycle (another master pulled SCL low), go to LOW at once, pulse `o_scl_fall` and do not pulse `o_mid_high` if it has not yet fired.
  - At cnt = H-1, go to LOW and pulse `o_scl_fall`.
- Pending stop: set by `i_SCL_stop` in any non-IDLE state. It is ignored in IDLE.
- Stop and start in the same cycle while IDLE: start wins and the stop is dropped.
- `i_SCL_en`=0 in any state: next state is IDLE and `o_scl_oe`=0. No `o_done` pulse. Pending stop is cleared. `i_SCL_start` is ignored while disabled.
- All strobes are registered and asserted in the first cycle of the new state. The exception is the mid strobes, which assert in the cycle where cnt = H>>1.

## Timing
- Reset values: state IDLE, `o_scl_oe`=0, `o_SCL`=1, `o_busy`=0, all strobes 0, `cnt`=0, stretch counter 0, pending stop 0, `h_q`=1, synchroniser flops 1.
- Start latency: `i_SCL_start` sampled at edge k gives `o_scl_oe`=1 and `o_scl_fall`=1 after edge k.
- Unstretched timing on an ideal pull-up bus (`i_SCL_in` = `~o_scl_oe`):
  - LOW lasts H cycles;
  - HWAIT lasts 2 cycles (synchroniser latency);
  - HIGH lasts H cycles;
  - period = 2H+2 cycles.
- Stretching by S extra low cycles lengthens HWAIT to 2+S cycles.
- Stop latency: IDLE is entered after the last LOW cycle of the current or next low phase. SCL ends released and high.

## Test plan
- Basic clock: TWIBR=4, TWPS=0, ideal bus, start -> LOW 5 cycles, HWAIT 2, HIGH 5, period 12. Check `o_mid_low` at LOW cnt 2, `o_mid_high` at HIGH cnt 2, and one rise and one fall per period.
- Prescaler and divider change: TWIBR=1, TWPS=2 gives H=32. Change to TWIBR=0, TWPS=0 mid-HIGH -> the current HIGH keeps 32 cycles and the next LOW is 1 cycle (H=1, mid strobe at cnt 0).
- Stretch: hold `i_SCL_in` low 20 cycles after release -> HWAIT lasts 22 cycles and period = 2H+22. Then STRETCH_TO=16 with the line held low -> `o_stretch_to` pulses 16 cycles into HWAIT, state goes IDLE, `o_busy`=0.
- Clock sync: force `i_SCL_in` low at HIGH cnt 1 with H=5 -> LOW is entered 2 cycles later (synchroniser), `o_scl_fall` pulses and `o_mid_high` is absent for that period.
- Stop: pulse `i_SCL_stop` during HIGH -> the following LOW completes H cycles, then `o_done` pulses, `o_scl_oe`=0 is held and `o_busy`=0. A stop pulse in IDLE has no effect.
- Reset/enable mid-operation:
  - assert `i_rst` during LOW -> `o_scl_oe`=0 asynchronously with all reset values;
  - drop `i_SCL_en` during HIGH -> IDLE next cycle with no `o_done`, and a restart works normally.
